// File: rtl/cpu_pkg.sv
// cpu_pkg: shared core types (word, register index, bypass source) and the hard-wired zero register index.
package cpu_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0] creg_addr_t;
  typedef struct packed {
    logic       we;
    creg_addr_t wa;
    word_t      wd;
  } bypass_t;
  localparam creg_addr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/operand_bypass_mux.sv
// operand_bypass_mux: priority-selects one source operand from zero, EX, MEM, WB bypass or RegFile data.
//   src in: source register index; rf in: RegFile read data; ex/mem/wb in: producer write ports;
//   ex_is_load in: EX result is a load (value not yet available); val out: resolved operand.
module operand_bypass_mux
  import cpu_pkg::*;
(
  input  creg_addr_t src,
  input  word_t      rf,
  input  bypass_t    ex,
  input  logic       ex_is_load,
  input  bypass_t    mem,
  input  bypass_t    wb,
  output word_t      val
);
  // WB is still needed because the RegFile write lands at the same edge this stage samples.
  always_comb
    val = (src == REG_ZERO)                          ? '0     :
          (ex.we && ex.wa == src && !ex_is_load)     ? ex.wd  :
          (mem.we && mem.wa == src)                  ? mem.wd :
          (wb.we && wb.wa == src)                    ? wb.wd  : rf;
endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: decode-to-execute operand stage with RegFile read, EX/MEM/WB bypass, load-use stall and D/E register.
//   clk/resetn: clock and async active-low reset; flush: squash stage and its input.
//   in_*: decoder handshake and payload; ra1/ra2 out, rd1/rd2 in: RegFile read ports.
//   ex_*/mem_*/wb_*: producer ports for bypass; out_*: D/E register with valid/ready; stall_cnt: saturating load-use stall count.
module operand_fetch_stage
  import cpu_pkg::*;
#(
  parameter int CTRL_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_wa,
  input  logic              in_we,
  input  logic              in_is_load,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic [4:0]        ra1,
  output logic [4:0]        ra2,
  input  logic [31:0]       rd1,
  input  logic [31:0]       rd2,
  input  logic              ex_we,
  input  logic [4:0]        ex_wa,
  input  logic [31:0]       ex_wd,
  input  logic              ex_is_load,
  input  logic              mem_we,
  input  logic [4:0]        mem_wa,
  input  logic [31:0]       mem_wd,
  input  logic              wb_we,
  input  logic [4:0]        wb_wa,
  input  logic [31:0]       wb_wd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_a,
  output logic [31:0]       out_b,
  output logic [4:0]        out_wa,
  output logic              out_we,
  output logic              out_is_load,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [31:0]       stall_cnt
);
  bypass_t ex_b, mem_b, wb_b;
  word_t a_sel, b_sel;
  logic hazard, advance, load;
  logic valid_q, valid_d, we_q, we_d, ld_q, ld_d;
  word_t a_q, a_d, b_q, b_d, stall_q, stall_d;
  creg_addr_t wa_q, wa_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  assign ex_b  = '{we: ex_we,  wa: ex_wa,  wd: ex_wd};
  assign mem_b = '{we: mem_we, wa: mem_wa, wd: mem_wd};
  assign wb_b  = '{we: wb_we,  wa: wb_wa,  wd: wb_wd};
  assign ra1 = in_rs;
  assign ra2 = in_rt;
  operand_bypass_mux u_mux_a (.src(in_rs), .rf(rd1), .ex(ex_b), .ex_is_load(ex_is_load), .mem(mem_b), .wb(wb_b), .val(a_sel));
  operand_bypass_mux u_mux_b (.src(in_rt), .rf(rd2), .ex(ex_b), .ex_is_load(ex_is_load), .mem(mem_b), .wb(wb_b), .val(b_sel));
  // A load in EX has no data yet, so a dependent instruction must wait one cycle for it to reach MEM.
  assign hazard   = in_valid && ex_we && ex_is_load && ex_wa != REG_ZERO && (ex_wa == in_rs || ex_wa == in_rt);
  assign advance  = !valid_q || out_ready;
  assign in_ready = flush || (advance && !hazard);
  assign load     = !flush && advance && in_valid && !hazard;
  always_comb begin
    valid_d = flush ? 1'b0 : advance ? load : valid_q;
    a_d     = load ? a_sel : a_q;
    b_d     = load ? b_sel : b_q;
    wa_d    = load ? in_wa : wa_q;
    we_d    = load ? in_we : we_q;
    ld_d    = load ? in_is_load : ld_q;
    ctrl_d  = load ? in_ctrl : ctrl_q;
    stall_d = (!flush && advance && hazard && stall_q != '1) ? stall_q + 32'd1 : stall_q;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      wa_q    <= '0;
      we_q    <= 1'b0;
      ld_q    <= 1'b0;
      ctrl_q  <= '0;
      stall_q <= '0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      wa_q    <= wa_d;
      we_q    <= we_d;
      ld_q    <= ld_d;
      ctrl_q  <= ctrl_d;
      stall_q <= stall_d;
    end
  assign out_valid   = valid_q;
  assign out_a       = a_q;
  assign out_b       = b_q;
  assign out_wa      = wa_q;
  assign out_we      = we_q;
  assign out_is_load = ld_q;
  assign out_ctrl    = ctrl_q;
  assign stall_cnt   = stall_q;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb_operand_fetch_stage: scoreboard bench for operand select, bypass priority, load-use stall, backpressure, flush and reset.
module tb_operand_fetch_stage;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  wa;
    logic        we;
    logic        ld;
    logic [31:0] ctrl;
  } exp_t;
  logic clk = 1'b0, resetn = 1'b0, flush = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [4:0] in_rs = '0, in_rt = '0, in_wa = '0;
  logic in_we = 1'b0, in_is_load = 1'b0;
  logic [31:0] in_ctrl = '0;
  logic [4:0] ra1, ra2;
  logic [31:0] rd1 = '0, rd2 = '0;
  logic ex_we = 1'b0, ex_is_load = 1'b0, mem_we = 1'b0, wb_we = 1'b0;
  logic [4:0] ex_wa = '0, mem_wa = '0, wb_wa = '0;
  logic [31:0] ex_wd = '0, mem_wd = '0, wb_wd = '0;
  logic out_valid, out_ready = 1'b1;
  logic [31:0] out_a, out_b, out_ctrl, stall_cnt;
  logic [4:0] out_wa;
  logic out_we, out_is_load;
  exp_t sb[$];
  exp_t e;
  int vectors = 0, miscompares = 0;
  logic [31:0] s0;
  operand_fetch_stage dut (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_wa(in_wa), .in_we(in_we), .in_is_load(in_is_load), .in_ctrl(in_ctrl),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .ex_we(ex_we), .ex_wa(ex_wa), .ex_wd(ex_wd), .ex_is_load(ex_is_load),
    .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_wa(out_wa), .out_we(out_we), .out_is_load(out_is_load), .out_ctrl(out_ctrl), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  function automatic exp_t obs();
    return {out_a, out_b, out_wa, out_we, out_is_load, out_ctrl};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic launch(input logic [31:0] ea, input logic [31:0] eb);
    sb.push_back({ea, eb, in_wa, in_we, in_is_load, in_ctrl});
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask
  task automatic test_reset();
    vectors++;
    if (out_valid !== 1'b0 || obs() !== '0 || stall_cnt !== '0) begin
      miscompares++;
      $display("FAIL reset_init: valid=%b outs=%h stall=%h want 0", out_valid, obs(), stall_cnt);
    end
  endtask
  task automatic test_basic();
    in_rs = 5; in_rt = 6; rd1 = 32'h11; rd2 = 32'h22; in_wa = 3; in_we = 1; in_ctrl = 32'hC0DE_0001;
    #1;
    vectors++;
    if (ra1 !== 5'd5 || ra2 !== 5'd6 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_ports: ra1=%0d ra2=%0d rdy=%b want 5 6 1", ra1, ra2, in_ready);
    end
    launch(32'h11, 32'h22);
    vectors++;
    if (!out_valid || sb.size() == 0) begin
      miscompares++;
      $display("FAIL basic_out: valid=%b want 1", out_valid);
    end else begin
      e = sb.pop_front();
      if (obs() !== e) begin miscompares++; $display("FAIL basic_out: got %h want %h", obs(), e); end
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_drain: valid=%b want 0", out_valid); end
  endtask
  task automatic test_bypass();
    logic [31:0] want [4];
    want[0] = 32'hA; want[1] = 32'hB; want[2] = 32'hC; want[3] = 32'h11;
    in_rs = 5; in_rt = 5; rd1 = 32'h11; rd2 = 32'h11; in_wa = 8; in_ctrl = 32'hB0B0;
    ex_we = 1; ex_wa = 5; ex_wd = 32'hA;
    mem_we = 1; mem_wa = 5; mem_wd = 32'hB;
    wb_we = 1; wb_wa = 5; wb_wd = 32'hC;
    for (int i = 0; i < 4; i++) begin
      launch(want[i], want[i]);
      vectors++;
      if (!out_valid || sb.size() == 0) begin
        miscompares++;
        $display("FAIL bypass_%0d: valid=%b want 1", i, out_valid);
      end else begin
        e = sb.pop_front();
        if (obs() !== e) begin miscompares++; $display("FAIL bypass_%0d: got %h want %h", i, obs(), e); end
      end
      if (i == 0) ex_we = 0;
      if (i == 1) mem_we = 0;
      if (i == 2) wb_we = 0;
    end
  endtask
  task automatic test_zero();
    s0 = stall_cnt;
    in_rs = 0; in_rt = 6; rd1 = 32'h55; rd2 = 32'h66; ex_we = 1; ex_wa = 0; ex_wd = 32'hFFFF; ex_is_load = 0;
    launch(32'h0, 32'h66);
    vectors++;
    if (!out_valid || sb.size() == 0) begin
      miscompares++;
      $display("FAIL zero_reg: valid=%b want 1", out_valid);
    end else begin
      e = sb.pop_front();
      if (obs() !== e) begin miscompares++; $display("FAIL zero_reg: got %h want %h", obs(), e); end
    end
    ex_is_load = 1; in_valid = 1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL zero_load_ready: rdy=%b want 1", in_ready); end
    in_valid = 0; ex_we = 0; ex_is_load = 0;
    vectors++;
    if (stall_cnt !== s0) begin miscompares++; $display("FAIL zero_nostall: stall=%0d want %0d", stall_cnt, s0); end
  endtask
  task automatic test_load_use();
    s0 = stall_cnt;
    ex_we = 1; ex_is_load = 1; ex_wa = 7; ex_wd = 32'h77;
    in_rs = 1; in_rt = 7; rd1 = 32'h10; rd2 = 32'h70; in_wa = 9; in_is_load = 0; in_ctrl = 32'h1D;
    in_valid = 1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL lu_ready: rdy=%b want 0", in_ready); end
    tick();
    vectors++;
    if (out_valid !== 1'b0 || stall_cnt !== s0 + 1) begin
      miscompares++;
      $display("FAIL lu_bubble: valid=%b stall=%0d want 0 %0d", out_valid, stall_cnt, s0 + 1);
    end
    ex_we = 0; ex_is_load = 0; mem_we = 1; mem_wa = 7; mem_wd = 32'h99;
    launch(32'h10, 32'h99);
    vectors++;
    if (!out_valid || sb.size() == 0) begin
      miscompares++;
      $display("FAIL lu_resolve: valid=%b want 1", out_valid);
    end else begin
      e = sb.pop_front();
      if (obs() !== e) begin miscompares++; $display("FAIL lu_resolve: got %h want %h", obs(), e); end
    end
    mem_we = 0;
  endtask
  task automatic test_backpressure();
    in_rs = 2; in_rt = 3; rd1 = 32'h2; rd2 = 32'h3; in_wa = 4; in_we = 1; in_ctrl = 32'hAAAA;
    launch(32'h2, 32'h3);
    out_ready = 0;
    s0 = stall_cnt;
    in_rs = 12; in_rt = 13; rd1 = 32'hDEAD; rd2 = 32'hBEEF; in_ctrl = 32'h5555; in_valid = 1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready: rdy=%b want 0", in_ready); end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || sb.size() == 0 || obs() !== sb[0]) begin
      miscompares++;
      $display("FAIL bp_hold1: valid=%b got %h", out_valid, obs());
    end
    ex_we = 1; ex_is_load = 1; ex_wa = 12;
    tick();
    vectors++;
    if (stall_cnt !== s0 || out_valid !== 1'b1 || sb.size() == 0 || obs() !== sb[0]) begin
      miscompares++;
      $display("FAIL bp_hold2: stall=%0d want %0d valid=%b got %h", stall_cnt, s0, out_valid, obs());
    end
    ex_we = 0; ex_is_load = 0; flush = 1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_ready: rdy=%b want 1", in_ready); end
    tick();
    flush = 0; in_valid = 0; out_ready = 1;
    sb.delete();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid: valid=%b want 0", out_valid); end
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_drop: valid=%b want 0", out_valid); end
  endtask
  task automatic test_back_to_back();
    logic [31:0] ea, eb;
    in_valid = 1;
    for (int i = 0; i < 16; i++) begin
      in_rs = 5'($urandom_range(1, 31)); in_rt = 5'($urandom_range(1, 31));
      rd1 = $urandom; rd2 = $urandom; in_wa = 5'($urandom); in_we = 1'($urandom); in_is_load = 1'($urandom);
      in_ctrl = $urandom;
      mem_we = 1'($urandom); mem_wa = (i % 3 == 0) ? in_rs : in_rt; mem_wd = $urandom;
      ea = (mem_we && mem_wa == in_rs) ? mem_wd : rd1;
      eb = (mem_we && mem_wa == in_rt) ? mem_wd : rd2;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_%0d: rdy=%b want 1", i, in_ready); end
      sb.push_back({ea, eb, in_wa, in_we, in_is_load, in_ctrl});
      tick();
      vectors++;
      if (!out_valid || sb.size() == 0) begin
        miscompares++;
        $display("FAIL b2b_%0d: valid=%b want 1", i, out_valid);
      end else begin
        e = sb.pop_front();
        if (obs() !== e) begin miscompares++; $display("FAIL b2b_%0d: got %h want %h", i, obs(), e); end
      end
    end
    in_valid = 0; mem_we = 0; in_is_load = 0;
  endtask
  task automatic test_reset_mid();
    in_rs = 5; in_rt = 6; rd1 = 32'h123; rd2 = 32'h456; in_wa = 7; in_we = 1; in_ctrl = 32'hFACE;
    launch(32'h123, 32'h456);
    vectors++;
    if (out_valid !== 1'b1 || stall_cnt === '0) begin
      miscompares++;
      $display("FAIL reset_pre: valid=%b stall=%0d want 1 nonzero", out_valid, stall_cnt);
    end
    #2;
    resetn = 0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || obs() !== '0 || stall_cnt !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: valid=%b outs=%h stall=%h want 0", out_valid, obs(), stall_cnt);
    end
    sb.delete();
    tick();
    resetn = 1;
  endtask
  initial begin
    tick();
    tick();
    test_reset();
    resetn = 1;
    tick();
    test_basic();
    test_bypass();
    test_zero();
    test_load_use();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
